// File: rtl/pe_link_arbiter.sv
// ---------------------------------------------------------------------------
// pe_link_arbiter
// Two-input, one-output packet arbiter for a PE tile's east link. Flits from
// the north and west neighbours share the registered out_to_east channel.
// Once a packet has started from one side, that side keeps the link until
// its last flit has been sent.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   ap_start                one-cycle pulse that enables arbitration
//   in_from_north/north_*   north flit data, valid, last; north_ready out
//   in_from_west/west_*     west flit data, valid, last; west_ready out
//   out_to_east/east_*      registered output flit, valid, last; east_ready in
//   busy                    high once started
//   pkt_cnt                 count of last flits delivered on east (wraps)
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, north always wins ties and the
//                      round-robin pointer is removed.
// ---------------------------------------------------------------------------
module pe_link_arbiter #(
   parameter int unsigned EAST_WIDTH   = 130,
   parameter int unsigned PKT_CNT_BITS = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ap_start,
   input  logic [EAST_WIDTH-1:0]   in_from_north,
   input  logic                    north_valid,
   input  logic                    north_last,
   output logic                    north_ready,
   input  logic [EAST_WIDTH-1:0]   in_from_west,
   input  logic                    west_valid,
   input  logic                    west_last,
   output logic                    west_ready,
   output logic [EAST_WIDTH-1:0]   out_to_east,
   output logic                    east_valid,
   output logic                    east_last,
   input  logic                    east_ready,
   output logic                    busy,
   output logic [PKT_CNT_BITS-1:0] pkt_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARB    = 2'd1,
      S_LOCK_N = 2'd2,
      S_LOCK_W = 2'd3
   } state_e;

   state_e                  state_q, state_d;

   logic [EAST_WIDTH-1:0]   east_data_q, east_data_d;
   logic                    east_last_q, east_last_d;
   logic                    east_valid_q, east_valid_d;
   logic                    busy_q, busy_d;
   logic [PKT_CNT_BITS-1:0] pkt_cnt_q, pkt_cnt_d;

   logic                    slot_free;
   logic                    acc_n;
   logic                    acc_w;
   logic                    pkt_done;

`ifndef ARB_FIXED_PRIO_EN
   localparam logic SIDE_N = 1'b0;
   localparam logic SIDE_W = 1'b1;

   // Round-robin pointer: side that wins the next tie in ARB.
   logic rr_q, rr_d;
`endif

   // Output slot can take a new flit when empty or draining this cycle.
   assign slot_free = !east_valid_q || east_ready;

   // Handshake completions; at most one side is granted in any cycle.
   assign acc_n    = north_ready && north_valid;
   assign acc_w    = west_ready && west_valid;
   assign pkt_done = (acc_n && north_last) || (acc_w && west_last);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            // Single-flit packets leave the arbiter free for the next pick.
            if (acc_n && !north_last) begin
               state_d = S_LOCK_N;
            end else if (acc_w && !west_last) begin
               state_d = S_LOCK_W;
            end
         end
         S_LOCK_N: begin
            if (acc_n && north_last) begin
               state_d = S_ARB;
            end
         end
         S_LOCK_W: begin
            if (acc_w && west_last) begin
               state_d = S_ARB;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Ready generation. Each ready depends on the state, the output slot and
   // only the other side's valid, so a source never sees its own valid fed
   // back into its ready.
   always_comb begin
      north_ready = 1'b0;
      west_ready  = 1'b0;
      case (state_q)
         S_ARB: begin
`ifdef ARB_FIXED_PRIO_EN
            north_ready = slot_free;
            west_ready  = slot_free && !north_valid;
`else
            north_ready = slot_free && ((rr_q == SIDE_N) || !west_valid);
            west_ready  = slot_free && ((rr_q == SIDE_W) || !north_valid);
`endif
         end
         S_LOCK_N: begin
            north_ready = slot_free;
         end
         S_LOCK_W: begin
            west_ready = slot_free;
         end
         default: begin
            north_ready = 1'b0;
            west_ready  = 1'b0;
         end
      endcase
   end

`ifndef ARB_FIXED_PRIO_EN
   // Pointer moves to the opposite side whenever a packet completes.
   always_comb begin
      rr_d = rr_q;
      if (pkt_done) begin
         rr_d = acc_n ? SIDE_W : SIDE_N;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q <= SIDE_N;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   // Output stage, status and packet counter.
   always_comb begin
      east_data_d  = east_data_q;
      east_last_d  = east_last_q;
      east_valid_d = east_valid_q;
      if (acc_n) begin
         east_data_d  = in_from_north;
         east_last_d  = north_last;
         east_valid_d = 1'b1;
      end else if (acc_w) begin
         east_data_d  = in_from_west;
         east_last_d  = west_last;
         east_valid_d = 1'b1;
      end else if (east_ready) begin
         east_valid_d = 1'b0;
      end

      busy_d    = busy_q || ((state_q == S_IDLE) && ap_start);
      pkt_cnt_d = pkt_cnt_q
                + PKT_CNT_BITS'(east_valid_q && east_ready && east_last_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         east_data_q  <= '0;
         east_last_q  <= 1'b0;
         east_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         pkt_cnt_q    <= '0;
      end else begin
         east_data_q  <= east_data_d;
         east_last_q  <= east_last_d;
         east_valid_q <= east_valid_d;
         busy_q       <= busy_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

   assign out_to_east = east_data_q;
   assign east_last   = east_last_q;
   assign east_valid  = east_valid_q;
   assign busy        = busy_q;
   assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_pe_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pe_link_arbiter
// Randomised and directed stimulus against a packet-level reference model.
// The driver predicts which input wins each cycle and queues the expected
// east flits; a separate monitor pops and compares them as they leave.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pe_link_arbiter;

   localparam int unsigned EW = 130;
   localparam int unsigned CW = 16;

   typedef struct packed {
      logic [EW-1:0] d;
      logic          last;
   } flit_t;

   logic          clk;
   logic          reset;
   logic          ap_start;
   logic [EW-1:0] in_from_north;
   logic          north_valid;
   logic          north_last;
   logic          north_ready;
   logic [EW-1:0] in_from_west;
   logic          west_valid;
   logic          west_last;
   logic          west_ready;
   logic [EW-1:0] out_to_east;
   logic          east_valid;
   logic          east_last;
   logic          east_ready;
   logic          busy;
   logic [CW-1:0] pkt_cnt;

   pe_link_arbiter #(.EAST_WIDTH(EW), .PKT_CNT_BITS(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .ap_start      (ap_start),
      .in_from_north (in_from_north),
      .north_valid   (north_valid),
      .north_last    (north_last),
      .north_ready   (north_ready),
      .in_from_west  (in_from_west),
      .west_valid    (west_valid),
      .west_last     (west_last),
      .west_ready    (west_ready),
      .out_to_east   (out_to_east),
      .east_valid    (east_valid),
      .east_last     (east_last),
      .east_ready    (east_ready),
      .busy          (busy),
      .pkt_cnt       (pkt_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Pending source traffic and expected east stream.
   flit_t n_q[$];
   flit_t w_q[$];
   flit_t exp_q[$];
   logic [CW-1:0] exp_pkt = '0;
   bit mon_en = 1'b0;

   // Reference model: started flag, lock owner (0 none, 1 N, 2 W),
   // tie-break side (0 N, 1 W), output slot occupancy.
   bit m_started = 1'b0;
   int m_lock    = 0;
   int m_rr      = 0;
   bit m_full    = 1'b0;

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_pkt(input bit side, input int len);
      flit_t f;
      for (int i = 0; i < len; i++) begin
         f.d    = EW'({$urandom, $urandom, $urandom, $urandom, $urandom});
         f.last = (i == len - 1);
         if (side) w_q.push_back(f);
         else      n_q.push_back(f);
      end
   endtask

   // One clock cycle: drive, predict grant, check handshakes, update model.
   task automatic cycle(input bit n_en, input bit w_en, input bit er, input bit start);
      bit    nv, wv, sf, gn, gw;
      flit_t f;
      @(negedge clk);
      nv = n_en && (n_q.size() != 0);
      wv = w_en && (w_q.size() != 0);
      north_valid   = nv;
      in_from_north = nv ? n_q[0].d : '0;
      north_last    = nv ? n_q[0].last : 1'b0;
      west_valid    = wv;
      in_from_west  = wv ? w_q[0].d : '0;
      west_last     = wv ? w_q[0].last : 1'b0;
      east_ready    = er;
      ap_start      = start;
      #2;
      sf = !m_full || er;
      gn = 1'b0;
      gw = 1'b0;
      if (m_started && sf) begin
         if (m_lock == 1)      gn = nv;
         else if (m_lock == 2) gw = wv;
         else if (nv && wv) begin
`ifdef ARB_FIXED_PRIO_EN
            gn = 1'b1;
`else
            if (m_rr == 0) gn = 1'b1;
            else           gw = 1'b1;
`endif
         end else begin
            gn = nv;
            gw = wv;
         end
      end
      chk("north_accept", EW'(north_ready && nv), EW'(gn));
      chk("west_accept", EW'(west_ready && wv), EW'(gw));
      chk("busy", EW'(busy), EW'(m_started));
      if (!m_started || !sf) begin
         chk("north_ready_blocked", EW'(north_ready), '0);
         chk("west_ready_blocked", EW'(west_ready), '0);
      end
      if (m_lock == 1) chk("west_ready_locked_out", EW'(west_ready), '0);
      if (m_lock == 2) chk("north_ready_locked_out", EW'(north_ready), '0);
      if (gn || gw) begin
         f = gn ? n_q.pop_front() : w_q.pop_front();
         exp_q.push_back(f);
         if (f.last) begin
            m_lock = 0;
            m_rr   = gn ? 1 : 0;
         end else begin
            m_lock = gn ? 1 : 2;
         end
      end
      m_full = gn || gw || (m_full && !er);
      if (start) m_started = 1'b1;
   endtask

   // Run with both sources enabled until they empty, bounded.
   task automatic drain();
      int n = 0;
      while ((n_q.size() != 0 || w_q.size() != 0) && n < 60) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b0);
         n++;
      end
      chk("drain_timeout", EW'(n_q.size() + w_q.size()), '0);
      repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Monitor: east output against the expected stream.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            chk("east_valid", EW'(east_valid), EW'(exp_q.size() != 0));
            chk("pkt_cnt", EW'(pkt_cnt), EW'(exp_pkt));
            if (east_valid && exp_q.size() != 0) begin
               chk("east_data", out_to_east, exp_q[0].d);
               chk("east_last", EW'(east_last), EW'(exp_q[0].last));
               if (east_ready) begin
                  if (exp_q[0].last) exp_pkt = exp_pkt + 1'b1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      ap_start      = 1'b0;
      in_from_north = '0;
      north_valid   = 1'b0;
      north_last    = 1'b0;
      in_from_west  = '0;
      west_valid    = 1'b0;
      west_last     = 1'b0;
      east_ready    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_east_valid", EW'(east_valid), '0);
      chk("reset_pkt_cnt", EW'(pkt_cnt), '0);
      chk("reset_out", out_to_east, '0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Valid traffic before ap_start is ignored.
      add_pkt(1'b0, 1);
      add_pkt(1'b1, 1);
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      n_q.delete();
      w_q.delete();

      // Start, then a lone north single-flit packet.
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      begin
         flit_t f;
         f.d    = EW'(1);
         f.last = 1'b1;
         n_q.push_back(f);
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("first_pkt_cnt", EW'(pkt_cnt), EW'(1));

      // Continuous single-flit packets on both sides.
      for (int i = 0; i < 8; i++) begin
         add_pkt(1'b0, 1);
         add_pkt(1'b1, 1);
      end
      drain();

      // West 4-flit packet with a 3-cycle gap; north arrives mid-packet.
      add_pkt(1'b1, 4);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      add_pkt(1'b0, 2);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      drain();

      // Downstream stall for 5 cycles with a flit held.
      add_pkt(1'b0, 2);
      add_pkt(1'b1, 1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      drain();

      // Randomised traffic, packet lengths 1..4, random gaps and stalls.
      for (int c = 0; c < 3000; c++) begin
         if (n_q.size() < 2) add_pkt(1'b0, int'($urandom_range(1, 4)));
         if (w_q.size() < 2) add_pkt(1'b1, int'($urandom_range(1, 4)));
         cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
               ($urandom % 50) == 0);
      end
      drain();

      // Asynchronous reset in the middle of a west packet.
      add_pkt(1'b1, 3);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      reset  = 1'b1;
      #1;
      chk("async_east_valid", EW'(east_valid), '0);
      chk("async_pkt_cnt", EW'(pkt_cnt), '0);
      chk("async_busy", EW'(busy), '0);
      chk("async_west_ready", EW'(west_ready), '0);
      north_valid = 1'b0;
      west_valid  = 1'b0;
      n_q.delete();
      w_q.delete();
      exp_q.delete();
      exp_pkt   = '0;
      m_started = 1'b0;
      m_lock    = 0;
      m_rr      = 0;
      m_full    = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Restart: a tie must go to north first.
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      add_pkt(1'b0, 1);
      add_pkt(1'b1, 1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      chk("restart_north_first", EW'(n_q.size()), '0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
